// File: rtl/prm_oblgc_sweep.sv
// Sweeps a contiguous range of checker query codes, one code per cycle, and packs
// the returned edge-mask bits into WORD_W-bit words on a valid/ready output stream.
module prm_oblgc_sweep #(
  parameter int IN_W   = 15,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IN_W-1:0]   base,
  input  logic [CNT_W-1:0]  count,
  output logic [IN_W-1:0]   chk_in,
  input  logic              chk_mask,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [IN_W-1:0]     r_chk_in;
  logic [CNT_W-1:0]    r_remaining;
  logic [IDX_W-1:0]    r_bit_idx;
  logic [WORD_W-1:0]   r_acc;
  logic [WORD_W-1:0]   r_word_data;
  logic                r_word_valid;
  logic                r_word_last;

  logic                w_accept;
  logic                w_final_query;
  logic                w_emit;
  logic                w_stall;
  logic                w_sample;
  logic                w_handshake;
  logic [WORD_W-1:0]   w_acc_next;

  assign w_accept      = start && (r_state == S_IDLE);
  assign w_final_query = (r_remaining == CNT_W'(1));
  assign w_emit        = (r_bit_idx == IDX_W'(WORD_W - 1)) || w_final_query;
  // A full output register only blocks the cycle that would overwrite it.
  assign w_stall       = r_word_valid && !word_ready && w_emit;
  assign w_sample      = (r_state == S_RUN) && !w_stall;
  assign w_handshake   = r_word_valid && word_ready;
  assign w_acc_next    = r_acc | (WORD_W'(chk_mask) << r_bit_idx);

  // NOTE: every next-state output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = (count == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_sample && w_final_query) w_state_next = S_DRAIN;
      S_DRAIN: if (w_handshake && r_word_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chk_in     <= '0;
      r_remaining  <= '0;
      r_bit_idx    <= '0;
      r_acc        <= '0;
      r_word_data  <= '0;
      r_word_valid <= 1'b0;
      r_word_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_chk_in    <= base;
        r_remaining <= count;
        r_bit_idx   <= '0;
        r_acc       <= '0;
      end

      if (w_handshake) begin
        r_word_valid <= 1'b0;
        r_word_last  <= 1'b0;
      end

      // A word load on the handshake edge overrides the clear above, so full rate has no bubble.
      if (w_sample) begin
        r_chk_in    <= r_chk_in + IN_W'(1);
        r_remaining <= r_remaining - CNT_W'(1);
        if (w_emit) begin
          r_word_data  <= w_acc_next;
          r_word_valid <= 1'b1;
          r_word_last  <= w_final_query;
          r_acc        <= '0;
          r_bit_idx    <= '0;
        end else begin
          r_acc     <= w_acc_next;
          r_bit_idx <= r_bit_idx + IDX_W'(1);
        end
      end
    end
  end

  assign chk_in     = r_chk_in;
  assign word_data  = r_word_data;
  assign word_valid = r_word_valid;
  assign word_last  = r_word_last;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_prm_oblgc_sweep.sv
// Scoreboard bench for prm_oblgc_sweep: a behavioural checker model drives chk_mask,
// expected words are queued per sweep and a negedge monitor compares handshaken words.
module tb_prm_oblgc_sweep;

  localparam int IN_W   = 15;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst;
  logic              start;
  logic [IN_W-1:0]   base;
  logic [CNT_W-1:0]  count;
  logic [IN_W-1:0]   chk_in;
  logic              chk_mask;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              word_last;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;

  int              mask_mode = 0;   // 0: all ones, 1: code[0], 2: keyed parity
  logic [IN_W-1:0] mask_key  = '0;
  int              ready_mode = 0;  // 0: always, 1: random, 2: hold low for stall_left cycles
  int              stall_left = 0;

  logic [WORD_W:0] expq[$];         // {last, data}
  logic            held;
  logic [WORD_W:0] held_word;

  prm_oblgc_sweep #(.IN_W(IN_W), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base       (base),
    .count      (count),
    .chk_in     (chk_in),
    .chk_mask   (chk_mask),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_last  (word_last),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic model_mask(input int mode, input logic [IN_W-1:0] code,
                                      input logic [IN_W-1:0] key);
    case (mode)
      0:       return 1'b1;
      1:       return code[0];
      default: return (^(code & key)) ^ code[IN_W-1];
    endcase
  endfunction

  always_comb chk_mask = model_mask(mask_mode, chk_in, mask_key);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready driver, updated just after each rising edge.
  initial begin
    word_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: word_ready = 1'b1;
        1: word_ready = 1'($urandom_range(0, 1));
        default: begin
          if (word_valid && stall_left > 0) begin
            word_ready = 1'b0;
            stall_left--;
          end else begin
            word_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: compares each handshaken word and checks hold-stability under backpressure.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else if (word_valid) begin
      if (held) check("hold_stable", {word_last, word_data}, held_word);
      if (word_ready) begin
        if (expq.size() == 0) begin
          check("extra_word", {word_last, word_data}, 64'hDEAD);
        end else begin
          check("word", {word_last, word_data}, expq.pop_front());
        end
        held = 1'b0;
      end else begin
        held      = 1'b1;
        held_word = {word_last, word_data};
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic pulse_start(input logic [IN_W-1:0] b, input logic [CNT_W-1:0] c);
    @(posedge clk);
    #1;
    start = 1'b1;
    base  = b;
    count = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    base  = IN_W'($urandom);
    count = CNT_W'($urandom);
  endtask

  // Queues the golden words for a sweep, then issues it.
  task automatic start_sweep(input logic [IN_W-1:0] b, input int c);
    int nw;
    nw = (c + WORD_W - 1) / WORD_W;
    for (int w = 0; w < nw; w++) begin
      logic [WORD_W-1:0] d;
      d = '0;
      for (int i = 0; i < WORD_W; i++) begin
        int k;
        k = w * WORD_W + i;
        if (k < c) d[i] = model_mask(mask_mode, b + IN_W'(k), mask_key);
      end
      expq.push_back({(w == nw - 1), d});
    end
    pulse_start(b, CNT_W'(c));
  endtask

  task automatic wait_done(input string name, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      cycles++;
    end
    check({name, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      @(negedge clk);
      check({name, "_done_pulse"}, {done, busy}, 2'b00);
    end
    check({name, "_all_words"}, expq.size(), 0);
    expq.delete();
  endtask

  initial begin
    int cyc;
    rst   = 1'b1;
    start = 1'b0;
    base  = '0;
    count = '0;
    held  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {chk_in, word_data, word_valid, word_last, busy, done}, '0);
    rst = 1'b0;

    // count=1, all-ones checker
    mask_mode = 0;
    start_sweep(15'h0005, 1);
    @(negedge clk);
    check("c1_chk_in0", chk_in, 15'h0005);
    check("c1_busy", busy, 1'b1);
    @(negedge clk);
    check("c1_chk_in1", chk_in, 15'h0006);
    wait_done("c1", cyc);
    check("c1_done_lat", cyc, 0);

    // count=32, mask = code[0]
    mask_mode = 1;
    start_sweep(15'h0000, 32);
    wait_done("c32", cyc);

    // count=33, all ones -> two words
    mask_mode = 0;
    start_sweep(15'h0000, 33);
    wait_done("c33", cyc);

    // wrap at the top of the code space
    mask_mode = 1;
    start_sweep(15'h7FFF, 3);
    @(negedge clk);
    check("wrap_0", chk_in, 15'h7FFF);
    @(negedge clk);
    check("wrap_1", chk_in, 15'h0000);
    @(negedge clk);
    check("wrap_2", chk_in, 15'h0001);
    wait_done("wrap", cyc);

    // count=96 with ready held low 10 cycles at the first word
    mask_mode  = 2;
    mask_key   = 15'h5A3C;
    ready_mode = 2;
    stall_left = 10;
    start_sweep(15'h1234, 96);
    wait_done("stall", cyc);
    ready_mode = 0;

    // count=0 -> done next cycle, no words
    start_sweep(15'h0100, 0);
    wait_done("c0", cyc);
    check("c0_done_lat", cyc, 0);

    // start while busy is ignored
    ready_mode = 1;
    start_sweep(15'h0040, 100);
    repeat (5) @(posedge clk);
    pulse_start(15'h2222, 16'd7);
    wait_done("busy_start", cyc);

    // reset mid-sweep aborts; next sweep runs cleanly
    start_sweep(15'h0300, 300);
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_outs", {chk_in, word_data, word_valid, word_last, busy, done}, '0);
    expq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_sweep(15'h0777, 45);
    wait_done("post_rst", cyc);

    // randomized sweeps
    for (int t = 0; t < 6; t++) begin
      mask_mode  = $urandom_range(0, 2);
      mask_key   = IN_W'($urandom);
      ready_mode = $urandom_range(0, 1);
      start_sweep(IN_W'($urandom), $urandom_range(1, 200));
      wait_done("rand", cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
